coin_acceptor: RTL and testbench

//   Upstream stage of the 15-unit vending FSM. Conditions two raw coin sensors (5 and 10 units),

---
 rtl/vending_pkg.sv | 31 +++
 rtl/coin_debounce.sv | 46 ++++
 rtl/coin_acceptor.sv | 162 ++++++++++++++++
 tb/tb_coin_acceptor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared constants for the vending front end: coin values, price, coin-type
// codes, coin acceptor state encodings and a saturating counter helper.
package vending_pkg;

  localparam int unsigned CREDIT_W   = 5;
  localparam int unsigned FIFO_DEPTH = 3;
  localparam int unsigned STAT_W     = 16;

  localparam logic [CREDIT_W-1:0] COIN5_VALUE  = 5'd5;
  localparam logic [CREDIT_W-1:0] COIN10_VALUE = 5'd10;
  localparam logic [CREDIT_W-1:0] PRICE        = 5'd15;

  // Coin-type codes stored in the acceptor queue
  localparam logic COIN_5  = 1'b0;
  localparam logic COIN_10 = 1'b1;

  // Coin acceptor state encodings
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  // Add a small increment to a counter, sticking at all-ones
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [1:0]        inc);
    logic [STAT_W:0] sum;
    sum = {1'b0, a} + (STAT_W+1)'(inc);
    return sum[STAT_W] ? '1 : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// Coin sensor conditioner: 2-FF synchroniser, debounce counter, rise detect.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   raw           asynchronous sensor input
//   coin_event    one-cycle pulse when the debounced level rises
module coin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic coin_event
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable;
  logic [CNT_W-1:0] count;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples that differ from it
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      stable     <= 1'b0;
      count      <= '0;
      coin_event <= 1'b0;
    end else begin
      sync_q1    <= raw;
      sync_q2    <= sync_q1;
      coin_event <= 1'b0;
      if (sync_q2 == stable) begin
        count <= '0;
      end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        count      <= '0;
        stable     <= sync_q2;
        coin_event <= sync_q2;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: gathers one purchase's coins (up to 3) and replays them
// back-to-back on price_1/price_2 for the downstream vending FSM.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   coin5_raw, coin10_raw  asynchronous coin sensors
//   price_1, price_2       one cycle per replayed 5 / 10 coin
//   busy                   high while draining or in holdoff
//   coin_reject            one-cycle pulse when coins are refused
//   credit                 value buffered for the current purchase
// Optional macro COIN_ACCEPTOR_STATS_EN adds saturating counters
//   stat_coin5, stat_coin10, stat_reject.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1000,
  parameter int unsigned HOLDOFF_CYCLES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  output logic       price_1,
  output logic       price_2,
  output logic       busy,
  output logic       coin_reject,
  output logic [4:0] credit
`ifdef COIN_ACCEPTOR_STATS_EN
  ,
  output logic [15:0] stat_coin5,
  output logic [15:0] stat_coin10,
  output logic [15:0] stat_reject
`endif
);

  localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HOLD_W  = $clog2(HOLDOFF_CYCLES + 1);

  logic                  ev5;
  logic                  ev10;
  logic [1:0]            state,  state_n;
  logic [FIFO_DEPTH-1:0] fifo,   fifo_n;
  logic [FCNT_W-1:0]     fcnt,   fcnt_n;
  logic [CREDIT_W-1:0]   credit_n;
  logic [TIMER_W-1:0]    timer,  timer_n;
  logic [HOLD_W-1:0]     hold,   hold_n;
  logic                  price_1_n, price_2_n, busy_n, reject_n;
  logic                  accepting, take5, take10;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
    .clock(clock), .reset(reset), .raw(coin5_raw), .coin_event(ev5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
    .clock(clock), .reset(reset), .raw(coin10_raw), .coin_event(ev10)
  );

  // Queue admission: 5 goes ahead of 10 when both arrive together
  assign accepting = (state == IDLE) || (state == COLLECT);
  assign take5     = accepting && ev5 && (fcnt < FCNT_W'(FIFO_DEPTH));
  assign take10    = accepting && ev10 &&
                     ((fcnt + FCNT_W'(take5)) < FCNT_W'(FIFO_DEPTH));

  // Next-state and datapath
  always_comb begin
    state_n   = state;
    fifo_n    = fifo;
    fcnt_n    = fcnt;
    credit_n  = credit;
    timer_n   = timer;
    hold_n    = hold;
    price_1_n = 1'b0;
    price_2_n = 1'b0;
    reject_n  = 1'b0;

    case (state)
      IDLE, COLLECT: begin
        if (take5)  fifo_n[fcnt] = COIN_5;
        if (take10) fifo_n[fcnt + FCNT_W'(take5)] = COIN_10;
        fcnt_n   = fcnt + FCNT_W'(take5) + FCNT_W'(take10);
        credit_n = credit + (take5 ? COIN5_VALUE : '0) + (take10 ? COIN10_VALUE : '0);
        reject_n = (ev5 && !take5) || (ev10 && !take10);
        if (take5 || take10) begin
          timer_n = '0;
          state_n = (credit_n >= PRICE) ? DRAIN : COLLECT;
        end else if (state == COLLECT) begin
          if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) state_n = DRAIN;
          else                                       timer_n = timer + TIMER_W'(1);
        end
      end
      DRAIN: begin
        reject_n = ev5 || ev10;
        if (fcnt != '0) begin
          price_1_n = (fifo[0] == COIN_5);
          price_2_n = (fifo[0] == COIN_10);
          fifo_n    = {1'b0, fifo[FIFO_DEPTH-1:1]};
          fcnt_n    = fcnt - FCNT_W'(1);
        end
        if (fcnt <= FCNT_W'(1)) begin
          state_n  = HOLDOFF;
          credit_n = '0;
          hold_n   = '0;
        end
      end
      HOLDOFF: begin
        reject_n = ev5 || ev10;
        if (hold == HOLD_W'(HOLDOFF_CYCLES - 1)) state_n = IDLE;
        else                                     hold_n  = hold + HOLD_W'(1);
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == DRAIN) || (state_n == HOLDOFF);
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      fifo        <= '0;
      fcnt        <= '0;
      credit      <= '0;
      timer       <= '0;
      hold        <= '0;
      price_1     <= 1'b0;
      price_2     <= 1'b0;
      busy        <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_n;
      fifo        <= fifo_n;
      fcnt        <= fcnt_n;
      credit      <= credit_n;
      timer       <= timer_n;
      hold        <= hold_n;
      price_1     <= price_1_n;
      price_2     <= price_2_n;
      busy        <= busy_n;
      coin_reject <= reject_n;
    end
  end

`ifdef COIN_ACCEPTOR_STATS_EN
  logic [1:0] rej_inc;
  assign rej_inc = {1'b0, ev5 && !take5} + {1'b0, ev10 && !take10};

  // Accepted / rejected coin counters, sticky at full scale
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_coin5  <= '0;
      stat_coin10 <= '0;
      stat_reject <= '0;
    end else begin
      stat_coin5  <= sat_add(stat_coin5,  {1'b0, take5});
      stat_coin10 <= sat_add(stat_coin10, {1'b0, take10});
      stat_reject <= sat_add(stat_reject, rej_inc);
    end
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with short debounce/timeout settings.
module tb_coin_acceptor;

  logic       clock;
  logic       reset;
  logic       coin5_raw;
  logic       coin10_raw;
  logic       price_1;
  logic       price_2;
  logic       busy;
  logic       coin_reject;
  logic [4:0] credit;
`ifdef COIN_ACCEPTOR_STATS_EN
  logic [15:0] stat_coin5;
  logic [15:0] stat_coin10;
  logic [15:0] stat_reject;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (20),
    .HOLDOFF_CYCLES (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .coin5_raw  (coin5_raw),
    .coin10_raw (coin10_raw),
    .price_1    (price_1),
    .price_2    (price_2),
    .busy       (busy),
    .coin_reject(coin_reject),
    .credit     (credit)
`ifdef COIN_ACCEPTOR_STATS_EN
    ,
    .stat_coin5 (stat_coin5),
    .stat_coin10(stat_coin10),
    .stat_reject(stat_reject)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic steps(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clean 5-coin: 6 cycles high, 6 cycles low (debounced level back low at end)
  task automatic coin5_pulse();
    coin5_raw = 1'b1;
    steps(6);
    coin5_raw = 1'b0;
    steps(6);
  endtask

  initial begin
    reset      = 1'b1;
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    steps(3);
    chk("rst_credit", 16'(credit), 16'd0);
    chk("rst_price",  16'({price_2, price_1}), 16'd0);
    chk("rst_busy",   16'(busy), 16'd0);
    chk("rst_reject", 16'(coin_reject), 16'd0);
    reset = 1'b0;
    steps(2);

    // 10-coin held 8 cycles, then 5-coin: credit 10 -> 15, replay 10 then 5
    coin10_raw = 1'b1;
    steps(7);
    chk("a_credit10", 16'(credit), 16'd10);
    chk("a_busy_collect", 16'(busy), 16'd0);
    steps(1);
    coin10_raw = 1'b0;
    coin5_raw  = 1'b1;
    steps(6);
    chk("a_credit_wait", 16'(credit), 16'd10);
    steps(1);
    chk("a_credit15", 16'(credit), 16'd15);
    chk("a_busy_drain", 16'(busy), 16'd1);
    chk("a_price_pre", 16'({price_2, price_1}), 16'd0);
    coin5_raw = 1'b0;
    steps(1);
    chk("a_price_10", 16'({price_2, price_1}), 16'd2);
    steps(1);
    chk("a_price_5", 16'({price_2, price_1}), 16'd1);
    chk("a_credit_clr", 16'(credit), 16'd0);
    chk("a_busy_hold1", 16'(busy), 16'd1);
    steps(1);
    chk("a_price_end", 16'({price_2, price_1}), 16'd0);
    chk("a_busy_hold2", 16'(busy), 16'd1);
    steps(1);
    chk("a_busy_idle", 16'(busy), 16'd0);
    steps(10);

    // Three 5-coins: credit 5/10/15 then three cycles of price_1
    coin5_pulse();
    chk("b_credit5", 16'(credit), 16'd5);
    coin5_pulse();
    chk("b_credit10", 16'(credit), 16'd10);
    coin5_raw = 1'b1;
    steps(6);
    coin5_raw = 1'b0;
    steps(1);
    chk("b_credit15", 16'(credit), 16'd15);
    chk("b_price_pre", 16'({price_2, price_1}), 16'd0);
    steps(1);
    chk("b_price_a", 16'({price_2, price_1}), 16'd1);
    steps(1);
    chk("b_price_b", 16'({price_2, price_1}), 16'd1);
    steps(1);
    chk("b_price_c", 16'({price_2, price_1}), 16'd1);
    chk("b_credit_clr", 16'(credit), 16'd0);
    steps(1);
    chk("b_price_end", 16'({price_2, price_1}), 16'd0);
    steps(1);
    chk("b_busy_idle", 16'(busy), 16'd0);
    steps(4);

    // Single 5-coin then silence: timeout drains it, trailing 00
    coin5_pulse();
    chk("c_credit5", 16'(credit), 16'd5);
    steps(14);
    chk("c_not_yet", 16'(busy), 16'd0);
    chk("c_credit_hold", 16'(credit), 16'd5);
    steps(1);
    chk("c_busy_drain", 16'(busy), 16'd1);
    steps(1);
    chk("c_price_5", 16'({price_2, price_1}), 16'd1);
    chk("c_credit_clr", 16'(credit), 16'd0);
    steps(1);
    chk("c_price_gap", 16'({price_2, price_1}), 16'd0);
    chk("c_busy_hold", 16'(busy), 16'd1);
    steps(1);
    chk("c_busy_idle", 16'(busy), 16'd0);
    steps(4);

    // Both sensors together: 5 replayed first, then 10
    coin5_raw  = 1'b1;
    coin10_raw = 1'b1;
    steps(6);
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    steps(1);
    chk("d_credit15", 16'(credit), 16'd15);
    chk("d_busy", 16'(busy), 16'd1);
    steps(1);
    chk("d_price_5", 16'({price_2, price_1}), 16'd1);
    steps(1);
    chk("d_price_10", 16'({price_2, price_1}), 16'd2);
    steps(1);
    chk("d_price_end", 16'({price_2, price_1}), 16'd0);
    steps(1);
    chk("d_busy_idle", 16'(busy), 16'd0);
    steps(4);

    // 3-cycle glitch is shorter than the debounce window
    coin5_raw = 1'b1;
    steps(3);
    coin5_raw = 1'b0;
    steps(10);
    chk("e_glitch_credit", 16'(credit), 16'd0);
    chk("e_glitch_busy", 16'(busy), 16'd0);
    chk("e_glitch_reject", 16'(coin_reject), 16'd0);

    // 10-coin, 5-coin, and another 10-coin landing in the first DRAIN cycle
    coin10_raw = 1'b1;
    steps(6);
    coin10_raw = 1'b0;
    steps(5);
    coin5_raw = 1'b1;
    steps(1);
    coin10_raw = 1'b1;
    steps(5);
    chk("f_credit10", 16'(credit), 16'd10);
    chk("f_reject_pre", 16'(coin_reject), 16'd0);
    steps(1);
    chk("f_credit15", 16'(credit), 16'd15);
    chk("f_busy", 16'(busy), 16'd1);
    steps(1);
    chk("f_reject", 16'(coin_reject), 16'd1);
    chk("f_price_10", 16'({price_2, price_1}), 16'd2);
    chk("f_credit_kept", 16'(credit), 16'd15);
    steps(1);
    chk("f_reject_end", 16'(coin_reject), 16'd0);
    chk("f_price_5", 16'({price_2, price_1}), 16'd1);
    chk("f_credit_clr", 16'(credit), 16'd0);
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    steps(12);
    chk("f_busy_idle", 16'(busy), 16'd0);

    // Reset in the middle of collecting
    coin5_pulse();
    chk("g_credit_pre", 16'(credit), 16'd5);
    reset = 1'b1;
    steps(1);
    chk("g_credit_rst", 16'(credit), 16'd0);
    chk("g_busy_rst", 16'(busy), 16'd0);
    chk("g_price_rst", 16'({price_2, price_1}), 16'd0);
    reset = 1'b0;
    steps(25);
    chk("g_no_timeout", 16'(busy), 16'd0);
    chk("g_price_idle", 16'({price_2, price_1}), 16'd0);
    coin5_pulse();
    chk("g_fresh_credit", 16'(credit), 16'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
